// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts out one command byte on device clock edges and collects the ACK bit.
module ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned SETUP_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] tx_byte,
  input  logic       tx_start,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int unsigned MAX_A   = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] TO_FULL  = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQUEST,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    clk_sync, data_sync;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    edge_cnt, edge_cnt_nxt;
  logic [7:0]    byte_q, byte_nxt;
  logic          parity_q, parity_nxt;
  logic          nack_q, nack_nxt;
  logic          clk_oe_nxt, data_oe_nxt;
  logic          clk_fall, clk_s, data_s;

  assign clk_fall = ~clk_sync[1] & clk_sync[2];
  assign clk_s    = clk_sync[2];
  assign data_s   = data_sync[2];
  assign tx_busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      clk_sync    <= '0;
      data_sync   <= '0;
      cnt         <= '0;
      edge_cnt    <= '0;
      byte_q      <= '0;
      parity_q    <= 1'b0;
      nack_q      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      state       <= state_nxt;
      clk_sync    <= {clk_sync[1:0], ps2_clk};
      data_sync   <= {data_sync[1:0], ps2_data};
      cnt         <= cnt_nxt;
      edge_cnt    <= edge_cnt_nxt;
      byte_q      <= byte_nxt;
      parity_q    <= parity_nxt;
      nack_q      <= nack_nxt;
      ps2_clk_oe  <= clk_oe_nxt;
      ps2_data_oe <= data_oe_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    edge_cnt_nxt = edge_cnt;
    byte_nxt     = byte_q;
    parity_nxt   = parity_q;
    nack_nxt     = nack_q;
    clk_oe_nxt   = ps2_clk_oe;
    data_oe_nxt  = ps2_data_oe;
    tx_done      = 1'b0;
    tx_err       = 1'b0;

    case (state)
      IDLE: begin
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        if (tx_start) begin
          byte_nxt   = tx_byte;
          parity_nxt = ~^tx_byte;
          nack_nxt   = 1'b0;
          cnt_nxt    = '0;
          clk_oe_nxt = 1'b1;
          state_nxt  = INHIBIT;
        end
      end

      INHIBIT: begin
        if (cnt == INH_LAST) begin
          cnt_nxt     = '0;
          data_oe_nxt = 1'b1;
          state_nxt   = REQUEST;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      REQUEST: begin
        if (cnt == SET_LAST) begin
          cnt_nxt      = '0;
          clk_oe_nxt   = 1'b0;
          edge_cnt_nxt = '0;
          state_nxt    = SHIFT;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      default: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == TO_FULL) begin
          tx_done     = 1'b1;
          tx_err      = 1'b1;
          clk_oe_nxt  = 1'b0;
          data_oe_nxt = 1'b0;
          state_nxt   = IDLE;
        end else begin
          case (state)
            SHIFT: begin
              if (clk_fall) begin
                edge_cnt_nxt = edge_cnt + 4'd1;
                if (edge_cnt == 4'd9) begin
                  data_oe_nxt = 1'b0;
                  state_nxt   = ACK;
                end else if (edge_cnt == 4'd8) begin
                  data_oe_nxt = ~parity_q;
                end else begin
                  data_oe_nxt = ~byte_q[edge_cnt[2:0]];
                end
              end
            end
            ACK: begin
              if (clk_fall) begin
                nack_nxt  = data_s;
                state_nxt = WAIT_IDLE;
              end
            end
            WAIT_IDLE: begin
              if (clk_s && data_s) begin
                tx_done   = 1'b1;
                tx_err    = nack_q;
                state_nxt = IDLE;
              end
            end
            default: ;
          endcase
          // Lines are released one cycle ahead of the abort so the error pulse
          // coincides with both registered enables already at 0.
          if (cnt == TO_LAST) begin
            clk_oe_nxt  = 1'b0;
            data_oe_nxt = 1'b0;
          end
        end
      end
    endcase
  end

endmodule
